prog_clk_div: RTL and testbench

PROG_CLK_DIV -- requirements
Module: prog_clk_div

---
 rtl/prog_clk_div_pkg.sv | 16 +
 rtl/prog_clk_div_channel.sv | 52 +++++
 rtl/prog_clk_div.sv | 35 +++
 tb/tb_prog_clk_div.sv | 137 +++++++++++++
 4 files changed

// File: rtl/prog_clk_div_pkg.sv
// prog_clk_div_pkg: shared defaults and 100 MHz divisor constants for the programmable divider
package prog_clk_div_pkg;

    localparam int unsigned SYS_HZ    = 100_000_000;
    localparam int unsigned WIDTH_DEF = 20;

    // slow_clk toggles once per tick, so a full output period spans two divisor periods
    function automatic int unsigned div_for_hz(input int unsigned hz);
        return SYS_HZ / (2 * hz);
    endfunction

    localparam int unsigned DIV_100HZ       = div_for_hz(100);
    localparam int unsigned DIV_1HZ         = div_for_hz(1);
    localparam int unsigned DEFAULT_DIV_DEF = DIV_100HZ;

endpackage

// File: rtl/prog_clk_div_channel.sv
// div_channel: one divider channel with divisor register, wrap counter, tick pulse and square wave
module div_channel
    import prog_clk_div_pkg::*;
#(
    parameter int unsigned WIDTH       = WIDTH_DEF,
    parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] div_val,
    output logic             tick,
    output logic             slow_clk,
    output logic             active
);

    logic [WIDTH-1:0] div_q, div_d, cnt_q, cnt_d;
    logic             tick_q, tick_d, slow_q, slow_d, active_q, active_d;
    logic             run, wrap;

    always_comb begin
        run      = en && (div_q != '0);
        wrap     = run && (cnt_q == div_q - WIDTH'(1));
        div_d    = load ? div_val : div_q;
        cnt_d    = (load || wrap) ? '0 : run ? cnt_q + WIDTH'(1) : cnt_q;
        tick_d   = wrap && !load;
        slow_d   = load ? 1'b0 : slow_q ^ wrap;
        active_d = div_d != '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q    <= WIDTH'(DEFAULT_DIV);
            cnt_q    <= '0;
            tick_q   <= 1'b0;
            slow_q   <= 1'b0;
            active_q <= (DEFAULT_DIV != 0);
        end else begin
            div_q    <= div_d;
            cnt_q    <= cnt_d;
            tick_q   <= tick_d;
            slow_q   <= slow_d;
            active_q <= active_d;
        end
    end

    assign tick     = tick_q;
    assign slow_clk = slow_q;
    assign active   = active_q;

endmodule

// File: rtl/prog_clk_div.sv
// prog_clk_div: N_CH independent programmable tick/square-wave dividers sharing one clock
module prog_clk_div
    import prog_clk_div_pkg::*;
#(
    parameter int unsigned WIDTH       = WIDTH_DEF,
    parameter int unsigned N_CH        = 2,
    parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [N_CH-1:0]       load,
    input  logic [N_CH*WIDTH-1:0] div_val,
    output logic [N_CH-1:0]       tick,
    output logic [N_CH-1:0]       slow_clk,
    output logic [N_CH-1:0]       active
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        div_channel #(
            .WIDTH      (WIDTH),
            .DEFAULT_DIV(DEFAULT_DIV)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .en      (en),
            .load    (load[i]),
            .div_val (div_val[i*WIDTH +: WIDTH]),
            .tick    (tick[i]),
            .slow_clk(slow_clk[i]),
            .active  (active[i])
        );
    end

endmodule

// File: tb/tb_prog_clk_div.sv
// tb_prog_clk_div: directed checks of reset, periods, enable gaps, loads and reset override
module tb_prog_clk_div;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst, en;
    logic [1:0]   load;
    logic [2*W-1:0] div_val;
    logic [1:0]   tick, slow_clk, active;
    int           n_vec = 0;
    int           n_err = 0;

    prog_clk_div #(.WIDTH(W), .N_CH(2), .DEFAULT_DIV(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .load    (load),
        .div_val (div_val),
        .tick    (tick),
        .slow_clk(slow_clk),
        .active  (active)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; load = 2'b00; div_val = '0;
        step; step;
        chk("rst_tick", tick, 2'b00);
        chk("rst_slow", slow_clk, 2'b00);
        chk("rst_active", active, 2'b11);
        rst = 1'b0; en = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step;
            chk("def_tick", tick, (k % 4 == 0) ? 2'b11 : 2'b00);
            chk("def_slow", slow_clk, ((k / 4) % 2 == 1) ? 2'b11 : 2'b00);
        end

        div_val = {8'd5, 8'd3}; load = 2'b10;
        step;
        load = 2'b00;
        chk("ld1_tick", {1'b0, tick[1]}, 2'b00);
        chk("ld1_slow", {1'b0, slow_clk[1]}, 2'b00);
        for (int t = 1; t <= 17; t++) begin
            load = (t == 2) ? 2'b01 : 2'b00;
            step;
            load = 2'b00;
            chk("ch1_tick", {1'b0, tick[1]}, {1'b0, t % 5 == 0});
            chk("ch1_slow", {1'b0, slow_clk[1]}, {1'b0, (t / 5) % 2 == 1});
            chk("ch0_tick", {1'b0, tick[0]}, {1'b0, t > 2 && (t - 2) % 3 == 0});
            chk("ch0_slow", {1'b0, slow_clk[0]}, {1'b0, (t < 2) ? 1'b1 : ((t - 2) / 3) % 2 == 1});
        end

        div_val = {8'd4, 8'd4}; load = 2'b11;
        step;
        load = 2'b00;
        step; step;
        en = 1'b0;
        for (int g = 1; g <= 7; g++) begin
            step;
            chk("gap_tick", tick, 2'b00);
            chk("gap_slow", slow_clk, 2'b00);
        end
        en = 1'b1;
        step;
        chk("resume1_tick", tick, 2'b00);
        step;
        chk("resume2_tick", tick, 2'b11);
        chk("resume2_slow", slow_clk, 2'b11);

        div_val = {8'd4, 8'd0}; load = 2'b01;
        step;
        load = 2'b00;
        chk("zero_active", active, 2'b10);
        for (int k = 1; k <= 20; k++) begin
            step;
            chk("zero_tick", {1'b0, tick[0]}, 2'b00);
            chk("zero_slow", {1'b0, slow_clk[0]}, 2'b00);
        end
        div_val = {8'd4, 8'd1}; load = 2'b01;
        step;
        load = 2'b00;
        chk("one_ld_tick", {1'b0, tick[0]}, 2'b00);
        chk("one_active", active, 2'b11);
        for (int k = 1; k <= 6; k++) begin
            step;
            chk("one_tick", {1'b0, tick[0]}, 2'b01);
            chk("one_slow", {1'b0, slow_clk[0]}, {1'b0, k % 2 == 1});
        end

        div_val = {8'd4, 8'd1}; load = 2'b10;
        step;
        load = 2'b00;
        step; step; step;
        chk("prewrap_tick", {1'b0, tick[1]}, 2'b00);
        load = 2'b10;
        step;
        load = 2'b00;
        chk("wrapld_tick", {1'b0, tick[1]}, 2'b00);
        chk("wrapld_slow", {1'b0, slow_clk[1]}, 2'b00);
        for (int k = 1; k <= 4; k++) begin
            step;
            chk("postld_tick", {1'b0, tick[1]}, {1'b0, k == 4});
            chk("postld_slow", {1'b0, slow_clk[1]}, {1'b0, k == 4});
        end

        step; step;
        rst = 1'b1; load = 2'b11; div_val = {8'd7, 8'd7};
        step;
        chk("rstld_tick", tick, 2'b00);
        chk("rstld_slow", slow_clk, 2'b00);
        chk("rstld_active", active, 2'b11);
        rst = 1'b0; load = 2'b00;
        for (int k = 1; k <= 8; k++) begin
            step;
            chk("rstld_period", tick, (k % 4 == 0) ? 2'b11 : 2'b00);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
